// File: rtl/controlador_acesso_autenticacao_if.sv
// -----------------------------------------------------------------------------
// controlador_acesso_autenticacao_if
//
// Purpose: bundles the access-panel signals between the authentication
// comparator/user side and the access controller.
//
// Signals:
//   code_valid  1              confirm pulse, aut valid in this cycle
//   aut         3              comparator result, bit2 = highest privilege
//   relock      1              request to end a grant early
//   grant       3              one-hot granted level, or 000
//   deny        1              one-cycle pulse on a rejected attempt
//   locked      1              high during lockout
//   alarm       1              high during lockout
//   busy        1              high whenever the controller is not idle
//   fail_count  clog2(MAX+1)   consecutive failure count
//   grant_count 8              saturating grant counter (only with GRANT_COUNTER_EN)
//
// Modports:
//   master - panel side: drives code_valid/aut/relock, observes status
//   slave  - controller side
//
// Optional feature macro: GRANT_COUNTER_EN (adds grant_count).
// -----------------------------------------------------------------------------
interface controlador_acesso_autenticacao_if #(
  parameter int unsigned MAX_FAILS = 3
);
  localparam int unsigned FailW = $clog2(MAX_FAILS + 1);

  logic             code_valid;
  logic [2:0]       aut;
  logic             relock;
  logic [2:0]       grant;
  logic             deny;
  logic             locked;
  logic             alarm;
  logic             busy;
  logic [FailW-1:0] fail_count;
`ifdef GRANT_COUNTER_EN
  logic [7:0]       grant_count;
`endif

  modport master (
    output code_valid,
    output aut,
    output relock,
    input  grant,
    input  deny,
    input  locked,
    input  alarm,
    input  busy,
    input  fail_count
`ifdef GRANT_COUNTER_EN
    , input grant_count
`endif
  );

  modport slave (
    input  code_valid,
    input  aut,
    input  relock,
    output grant,
    output deny,
    output locked,
    output alarm,
    output busy,
    output fail_count
`ifdef GRANT_COUNTER_EN
    , output grant_count
`endif
  );

endinterface

// File: rtl/controlador_acesso_autenticacao.sv
// -----------------------------------------------------------------------------
// controlador_acesso_autenticacao
//
// Purpose: sequential access controller sitting behind the combinational
// authentication comparator. On a confirm it samples the 3-bit comparator
// result, resolves it to a single one-hot access level (highest bit wins),
// holds the grant for a timed window, counts consecutive failures and enforces
// a timed lockout with alarm once the failure streak reaches MAX_FAILS.
//
// Parameters:
//   UNLOCK_CYCLES  cycles a grant is held (>=1)
//   LOCK_CYCLES    cycles the lockout lasts (>=1)
//   MAX_FAILS      consecutive failures that trigger lockout (>=1)
//
// Ports:
//   clk     input  system clock, rising edge
//   rst_n   input  asynchronous active-low reset
//   io_bus  slave modport of controlador_acesso_autenticacao_if
//           (code_valid, aut, relock in; grant, deny, locked, alarm, busy,
//           fail_count out)
//
// Optional feature macro: GRANT_COUNTER_EN
//   defined   - io_bus.grant_count counts EVAL->GRANTED transitions,
//               saturating at 255
//   undefined - counter and port are absent
//
// All outputs are registered Moore outputs derived from the next state, so
// they change on the same edge the state does.
// -----------------------------------------------------------------------------
module controlador_acesso_autenticacao #(
  parameter int unsigned UNLOCK_CYCLES = 50,
  parameter int unsigned LOCK_CYCLES   = 200,
  parameter int unsigned MAX_FAILS     = 3
) (
  input logic                              clk,
  input logic                              rst_n,
  controlador_acesso_autenticacao_if.slave io_bus
);

  localparam int unsigned MaxCycles = (UNLOCK_CYCLES > LOCK_CYCLES) ? UNLOCK_CYCLES : LOCK_CYCLES;
  // clog2(1) is 0; keep at least one timer bit so the vector stays legal.
  localparam int unsigned TmrW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
  localparam int unsigned FailW     = $clog2(MAX_FAILS + 1);

  localparam logic [TmrW-1:0]  UnlockLoad = TmrW'(UNLOCK_CYCLES - 1);
  localparam logic [TmrW-1:0]  LockLoad   = TmrW'(LOCK_CYCLES - 1);
  localparam logic [FailW-1:0] MaxFailsV  = FailW'(MAX_FAILS);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StEval    = 3'd1,
    StGranted = 3'd2,
    StDenied  = 3'd3,
    StLockout = 3'd4
  } state_e;

  // State and datapath registers
  state_e           r_state;
  logic [2:0]       r_aut;
  logic [2:0]       r_level;
  logic [TmrW-1:0]  r_timer;
  logic [FailW-1:0] r_fail_cnt;

  // Registered outputs
  logic [2:0]       r_grant;
  logic             r_deny;
  logic             r_locked;
  logic             r_alarm;
  logic             r_busy;

  // Next-state values
  state_e           w_state_nxt;
  logic [2:0]       w_aut_nxt;
  logic [2:0]       w_level_nxt;
  logic [TmrW-1:0]  w_timer_nxt;
  logic [FailW-1:0] w_fail_nxt;
  logic             w_grant_evt;
  logic [2:0]       w_level_enc;
  logic             w_fail_room;

  // Highest set bit wins: 011 -> 010, 111 -> 100.
  always_comb begin
    w_level_enc = 3'b000;
    if (r_aut[2]) begin
      w_level_enc = 3'b100;
    end else if (r_aut[1]) begin
      w_level_enc = 3'b010;
    end else if (r_aut[0]) begin
      w_level_enc = 3'b001;
    end
  end

  // True while one more failure still stays below the lockout threshold.
  assign w_fail_room = (32'(r_fail_cnt) + 32'd1) < MAX_FAILS;

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_aut_nxt   = r_aut;
    w_level_nxt = r_level;
    w_timer_nxt = r_timer;
    w_fail_nxt  = r_fail_cnt;
    w_grant_evt = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (io_bus.code_valid) begin
          w_aut_nxt   = io_bus.aut;
          w_state_nxt = StEval;
        end
      end

      StEval: begin
        if (r_aut != 3'b000) begin
          w_level_nxt = w_level_enc;
          w_timer_nxt = UnlockLoad;
          w_fail_nxt  = '0;
          w_grant_evt = 1'b1;
          w_state_nxt = StGranted;
        end else if (w_fail_room) begin
          w_fail_nxt  = r_fail_cnt + FailW'(1);
          w_state_nxt = StDenied;
        end else begin
          w_fail_nxt  = MaxFailsV;
          w_timer_nxt = LockLoad;
          w_state_nxt = StLockout;
        end
      end

      StGranted: begin
        if ((r_timer == '0) || io_bus.relock) begin
          w_timer_nxt = '0;
          w_level_nxt = 3'b000;
          w_state_nxt = StIdle;
        end else begin
          w_timer_nxt = r_timer - TmrW'(1);
        end
      end

      StDenied: begin
        w_state_nxt = StIdle;
      end

      // relock is deliberately not looked at here.
      StLockout: begin
        if (r_timer == '0) begin
          w_fail_nxt  = '0;
          w_state_nxt = StIdle;
        end else begin
          w_timer_nxt = r_timer - TmrW'(1);
        end
      end

      default: begin
        w_state_nxt = StIdle;
        w_aut_nxt   = 3'b000;
        w_level_nxt = 3'b000;
        w_timer_nxt = '0;
        w_fail_nxt  = '0;
      end
    endcase
  end

  // State, datapath and registered Moore outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_aut      <= 3'b000;
      r_level    <= 3'b000;
      r_timer    <= '0;
      r_fail_cnt <= '0;
      r_grant    <= 3'b000;
      r_deny     <= 1'b0;
      r_locked   <= 1'b0;
      r_alarm    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_aut      <= w_aut_nxt;
      r_level    <= w_level_nxt;
      r_timer    <= w_timer_nxt;
      r_fail_cnt <= w_fail_nxt;
      r_grant    <= (w_state_nxt == StGranted) ? w_level_nxt : 3'b000;
      r_deny     <= (w_state_nxt == StDenied);
      r_locked   <= (w_state_nxt == StLockout);
      r_alarm    <= (w_state_nxt == StLockout);
      r_busy     <= (w_state_nxt != StIdle);
    end
  end

  assign io_bus.grant      = r_grant;
  assign io_bus.deny       = r_deny;
  assign io_bus.locked     = r_locked;
  assign io_bus.alarm      = r_alarm;
  assign io_bus.busy       = r_busy;
  assign io_bus.fail_count = r_fail_cnt;

`ifdef GRANT_COUNTER_EN
  logic [7:0] r_grant_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant_cnt <= 8'd0;
    end else if (w_grant_evt && (r_grant_cnt != 8'hFF)) begin
      r_grant_cnt <= r_grant_cnt + 8'd1;
    end
  end

  assign io_bus.grant_count = r_grant_cnt;
`else
  // Grant events only feed the optional counter.
  logic w_unused_grant_evt;
  assign w_unused_grant_evt = w_grant_evt;
`endif

endmodule

// File: tb/tb_controlador_acesso_autenticacao.sv
// -----------------------------------------------------------------------------
// tb_controlador_acesso_autenticacao
//
// Directed bench for controlador_acesso_autenticacao (UNLOCK=4, LOCK=6,
// MAX_FAILS=3). A transaction-level model turns each accepted confirm into the
// sequence of per-cycle output vectors it must produce; every cycle the DUT
// outputs are compared against the head of that sequence. Literal checks pin
// key values independently of the model.
// -----------------------------------------------------------------------------
module tb_controlador_acesso_autenticacao;

  localparam int unsigned U  = 4;
  localparam int unsigned L  = 6;
  localparam int unsigned M  = 3;
  localparam int unsigned FW = $clog2(M + 1);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  controlador_acesso_autenticacao_if #(.MAX_FAILS(M)) bus ();

  controlador_acesso_autenticacao #(
    .UNLOCK_CYCLES(U),
    .LOCK_CYCLES  (L),
    .MAX_FAILS    (M)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_bus(bus)
  );

  typedef struct packed {
    logic [2:0]    grant;
    logic          deny;
    logic          locked;
    logic          busy;
    logic [FW-1:0] fc;
    logic [7:0]    gc;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;

  vec_t exp_q[$];
  vec_t cur;
  bit   cur_idle;
  int   m_fails;
  int   m_gcnt;

  function automatic vec_t mk(logic [2:0] g, logic d, logic lk, logic b, int fc, int gc);
    vec_t v;
    v.grant  = g;
    v.deny   = d;
    v.locked = lk;
    v.busy   = b;
    v.fc     = FW'(fc);
    v.gc     = 8'(gc);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Called right after each rising edge with the inputs that edge sampled.
  task automatic model_step();
    logic [2:0] lvl;
    if (!rst_n) begin
      exp_q.delete();
      m_fails  = 0;
      m_gcnt   = 0;
      cur      = mk(3'b000, 1'b0, 1'b0, 1'b0, 0, 0);
      cur_idle = 1'b1;
      return;
    end
    if (cur_idle && bus.code_valid) begin
      exp_q.push_back(mk(3'b000, 1'b0, 1'b0, 1'b1, m_fails, m_gcnt));
      if (bus.aut != 3'b000) begin
        lvl = bus.aut[2] ? 3'b100 : (bus.aut[1] ? 3'b010 : 3'b001);
        m_fails = 0;
        if (m_gcnt < 255) m_gcnt++;
        repeat (U) exp_q.push_back(mk(lvl, 1'b0, 1'b0, 1'b1, 0, m_gcnt));
      end else if (m_fails + 1 < M) begin
        m_fails++;
        exp_q.push_back(mk(3'b000, 1'b1, 1'b0, 1'b1, m_fails, m_gcnt));
      end else begin
        repeat (L) exp_q.push_back(mk(3'b000, 1'b0, 1'b1, 1'b1, M, m_gcnt));
        m_fails = 0;
      end
    end else if (!cur_idle && bus.relock && (cur.grant != 3'b000)) begin
      exp_q.delete();
    end
    if (exp_q.size() > 0) begin
      cur      = exp_q.pop_front();
      cur_idle = 1'b0;
    end else begin
      cur      = mk(3'b000, 1'b0, 1'b0, 1'b0, m_fails, m_gcnt);
      cur_idle = 1'b1;
    end
  endtask

  task automatic compare();
    logic [8:0] act;
    logic [8:0] exp;
    act = {bus.grant, bus.deny, bus.locked, bus.alarm, bus.busy, bus.fail_count};
    exp = {cur.grant, cur.deny, cur.locked, cur.locked, cur.busy, cur.fc};
    chk($sformatf("cycle@%0t {grant,deny,locked,alarm,busy,fc}", $time), 32'(act), 32'(exp));
`ifdef GRANT_COUNTER_EN
    chk($sformatf("cycle@%0t grant_count", $time), 32'(bus.grant_count), 32'(cur.gc));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic confirm(input logic [2:0] a);
    bus.code_valid = 1'b1;
    bus.aut        = a;
    tick();
    bus.code_valid = 1'b0;
    bus.aut        = 3'b000;
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.code_valid = 1'b0;
    bus.aut        = 3'b000;
    bus.relock     = 1'b0;
    run(2);
    chk("reset grant", 32'(bus.grant), 32'd0);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset fail_count", 32'(bus.fail_count), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: single grant of the lowest level for exactly U cycles
    confirm(3'b001);
    chk("t1 eval busy", 32'(bus.busy), 32'd1);
    chk("t1 eval grant", 32'(bus.grant), 32'd0);
    tick();
    chk("t1 grant", 32'(bus.grant), 32'h1);
    run(U - 1);
    chk("t1 last grant cycle", 32'(bus.grant), 32'h1);
    tick();
    chk("t1 grant ends", 32'(bus.grant), 32'd0);
    chk("t1 idle busy", 32'(bus.busy), 32'd0);

    // 2: priority, ignored confirm while granted, early relock
    confirm(3'b110);
    tick();
    chk("t2 grant 110", 32'(bus.grant), 32'h4);
    bus.code_valid = 1'b1;
    bus.aut        = 3'b001;
    tick();
    bus.code_valid = 1'b0;
    bus.aut        = 3'b000;
    bus.relock     = 1'b1;
    tick();
    bus.relock     = 1'b0;
    chk("t2 relock grant", 32'(bus.grant), 32'd0);
    chk("t2 relock busy", 32'(bus.busy), 32'd0);
    run(2);
    confirm(3'b011);
    tick();
    chk("t2 grant 011", 32'(bus.grant), 32'h2);
    run(U);
    confirm(3'b111);
    tick();
    chk("t2 grant 111", 32'(bus.grant), 32'h4);
    run(U);

    // 3: two denies then lockout, inputs ignored during lockout
    confirm(3'b000);
    tick();
    chk("t3 deny1", 32'(bus.deny), 32'd1);
    chk("t3 fc1", 32'(bus.fail_count), 32'd1);
    tick();
    chk("t3 deny pulse width", 32'(bus.deny), 32'd0);
    confirm(3'b000);
    tick();
    chk("t3 fc2", 32'(bus.fail_count), 32'd2);
    tick();
    confirm(3'b000);
    tick();
    chk("t3 locked", 32'(bus.locked), 32'd1);
    chk("t3 alarm", 32'(bus.alarm), 32'd1);
    chk("t3 fc max", 32'(bus.fail_count), 32'd3);
    bus.code_valid = 1'b1;
    bus.aut        = 3'b100;
    bus.relock     = 1'b1;
    run(3);
    bus.code_valid = 1'b0;
    bus.aut        = 3'b000;
    bus.relock     = 1'b0;
    run(L - 4);
    chk("t3 last locked cycle", 32'(bus.locked), 32'd1);
    tick();
    chk("t3 unlocked", 32'(bus.locked), 32'd0);
    chk("t3 fc cleared", 32'(bus.fail_count), 32'd0);
    chk("t3 no grant", 32'(bus.grant), 32'd0);

    // 4: a grant breaks the failure streak
    confirm(3'b000);
    run(2);
    confirm(3'b000);
    run(2);
    confirm(3'b010);
    tick();
    chk("t4 grant", 32'(bus.grant), 32'h2);
    chk("t4 fc reset", 32'(bus.fail_count), 32'd0);
    run(U);
    confirm(3'b000);
    tick();
    chk("t4 deny", 32'(bus.deny), 32'd1);
    chk("t4 fc1", 32'(bus.fail_count), 32'd1);
    chk("t4 no lockout", 32'(bus.locked), 32'd0);
    tick();

    // 5: asynchronous reset mid-LOCKOUT and mid-GRANTED
    confirm(3'b000);
    run(2);
    confirm(3'b000);
    run(2);
    chk("t5 in lockout", 32'(bus.locked), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5 async locked", 32'(bus.locked), 32'd0);
    chk("t5 async alarm", 32'(bus.alarm), 32'd0);
    chk("t5 async fc", 32'(bus.fail_count), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    confirm(3'b001);
    run(2);
    chk("t5 in grant", 32'(bus.grant), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5 async grant", 32'(bus.grant), 32'd0);
    chk("t5 async busy", 32'(bus.busy), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    confirm(3'b100);
    tick();
    chk("t5 grant after reset", 32'(bus.grant), 32'h4);
    run(U);

`ifdef GRANT_COUNTER_EN
    // 6: grant counter saturates and ignores failures/lockout
    repeat (257) begin
      confirm(3'b001);
      bus.relock = 1'b1;
      run(2);
      bus.relock = 1'b0;
    end
    chk("t6 saturated", 32'(bus.grant_count), 32'd255);
    repeat (3) begin
      confirm(3'b000);
      tick();
    end
    run(L);
    chk("t6 after lockout", 32'(bus.grant_count), 32'd255);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/controlador_acesso_autenticacao.md
Name: controlador_acesso_autenticacao

Overview:
- Sequential access controller directly downstream of the combinational authentication comparator.
- Samples the comparator's 3-bit AUT result when the user confirms an entry.
- Resolves the result to a single access level, holds the grant for a timed window, counts consecutive failures and enforces a lockout with alarm.
- Drives the door/actuator and status LEDs of the access panel.

Parameters:
- UNLOCK_CYCLES, 50, cycles a grant is held (>=1).
- LOCK_CYCLES, 200, cycles the lockout lasts (>=1).
- MAX_FAILS, 3, consecutive failures that trigger lockout (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- code_valid  input  1  confirm pulse; AUT is valid and stable in this cycle.
- aut  input  3  comparator result; bit2 = highest privilege, bit0 = lowest.
- relock  input  1  user/door-closed request to end a grant early.
- grant  output  3  one-hot granted level, or 000.
- deny  output  1  one-cycle pulse on a rejected attempt.
- locked  output  1  high during lockout.
- alarm  output  1  high during lockout.
- busy  output  1  high in any state other than IDLE.
- fail_count  output  clog2(MAX_FAILS+1)  consecutive failure count.

Behaviour:
- All outputs are registered Moore outputs. In reset: state = IDLE, grant = 000, deny = locked = alarm = busy = 0, fail_count = 0, timer = 0, aut_q = 000.
- Timer width is clog2(max(UNLOCK_CYCLES, LOCK_CYCLES)).
- State IDLE: when code_valid = 1, capture aut into aut_q and go to EVAL. code_valid is ignored in every other state; no queuing.
- State EVAL (exactly 1 cycle, busy = 1):
  - aut_q != 000: priority-encode the highest set bit into a one-hot level, load timer = UNLOCK_CYCLES-1, clear fail_count, go to GRANTED.
  - aut_q == 000 and fail_count+1 < MAX_FAILS: increment fail_count, go to DENIED.
  - aut_q == 000 and fail_count+1 == MAX_FAILS: set fail_count = MAX_FAILS, load timer = LOCK_CYCLES-1, go to LOCKOUT.
- State GRANTED: grant = the stored one-hot level. Timer decrements each cycle; at timer == 0, or relock = 1, go to IDLE. grant is therefore high for exactly UNLOCK_CYCLES cycles, or fewer on relock.
- State DENIED (1 cycle): deny = 1, then go to IDLE.
- State LOCKOUT: locked = alarm = 1 for exactly LOCK_CYCLES cycles. relock is ignored. On exit go to IDLE and clear fail_count.
- Latency: code_valid sampled at edge k puts the FSM in EVAL in cycle k+1. grant, deny or locked becomes visible in cycle k+2.
- Multiple aut bits set (e.g. 011 or 111): the highest bit wins. 011 grants 010; 111 grants 100.
- Any successful grant resets the failure streak. Failures need not be contiguous in time, only uninterrupted by a grant.
- Asynchronous reset in any state immediately forces all outputs and counters to their reset values. No pending grant survives reset.
- Illegal or unreachable state encodings return to IDLE with all outputs cleared.

Optional Feature:
- Macro: GRANT_COUNTER_EN.
- Defined: adds output grant_count[7:0]. It increments on every EVAL->GRANTED transition, saturates at 255, resets to 0, and is unaffected by lockout.
- Undefined: the port and its counter are absent. All other behaviour is identical.

Test Plan (UNLOCK_CYCLES=4, LOCK_CYCLES=6, MAX_FAILS=3):
1. Reset release, then code_valid with aut=001 -> grant=001 from cycle k+2 for exactly 4 cycles; busy high throughout; fail_count=0.
2. aut=110 -> grant=100. A second code_valid pulse during GRANTED is ignored. relock asserted in the 2nd grant cycle -> grant=000 in the next cycle and state returns to IDLE.
3. Three confirms with aut=000 -> deny pulses twice with fail_count 1 then 2. The third confirm gives locked=alarm=1 for 6 cycles; code_valid and relock are ignored meanwhile; fail_count returns to 0 on exit.
4. Streak reset: aut=000, then aut=000, then aut=010 -> grant=010 and fail_count=0. A following aut=000 -> deny with fail_count=1, no lockout.
5. rst_n pulled low asynchronously mid-GRANTED and mid-LOCKOUT -> grant, locked and alarm drop without a clock edge; after release the FSM is in IDLE and accepts a new code.
6. With GRANT_COUNTER_EN defined: 257 successful grants -> grant_count saturates at 255. Failures and lockouts leave it unchanged.
